posit_round_encode_pipe: RTL and testbench
==========================================

// Module: posit_round_encode_pipe
// PURPOSE
//  Output stage of the posit multiply datapath. It takes the unrounded product fields
//  (sign, scale, normalised fraction, sticky, special flags) from the multiplier core.
//  It packs regime/exponent/fraction, rounds to nearest even, saturates and applies sign.
//  The result is an N-bit posit, delivered through a 2-stage valid/ready pipeline.
// PARAMETERS
//  N   8               posit width
//  ES  4               exponent field width
//  FW  N               input fraction width incl. hidden bit (in_frac[FW-1]==1)
//  Bs  log2(N)         derived; SW = Bs+ES+2 = scale width (signed)
// PORTS
//  clk        in   1    clock, all logic on posedge
//  rst        in   1    synchronous, active-high reset
//  in_valid   in   1    upstream fields valid
//  in_ready   out  1    stage accepts this cycle
//  in_sign    in   1    result sign
//  in_scale   in   SW   signed scale = k*2^ES + e
//  in_frac    in   FW   1.f normalised mantissa, MSB = hidden bit
//  in_sticky  in   1    OR of fraction bits already dropped upstream
//  in_inf     in   1    result is NaR
//  in_zero    in   1    result is zero
//  out_valid  out  1    out/out_inf/out_zero valid
//  out_ready  in   1    downstream accepts
//  out        out  N    encoded posit
//  out_inf    out  1    out == NaR
//  out_zero   out  1    out == 0
// BEHAVIOUR
//  - Reset: s1_valid=0, out_valid=0, out=0, out_inf=0, out_zero=0; in_ready=0 while rst=1.
//  - In-flight data is discarded by reset at any time; no output follows reset until a new accept.
//  - Handshakes: s2_adv = !out_valid | out_ready; s1_adv = !s1_valid | s2_adv; in_ready = s1_adv & !rst.
//    Transfer = valid & ready. Order preserved, no drop, no duplicate.
//  - Latency: 2 cycles from accept to out_valid while out_ready=1; full throughput 1/cycle.
//  - Outputs hold stable while out_valid & !out_ready.
//  - Stage 1 (registered): k = in_scale>>>ES; e = in_scale[ES-1:0].
//    Regime = (k+1) ones + 0 if k>=0, else (-k) zeros + 1.
//    Form {regime,e,frac[FW-2:0]} and right-align it to N-1 bits.
//    Capture the lsb, guard bit and sticky (dropped bits | in_sticky).
//  - Stage 2 (registered): RNE, i.e. round up iff guard & (lsb | sticky). Ties go to even.
//    A round carry may propagate into regime/exponent.
//  - Saturation: scale > (N-2)*2^ES gives mag 0x7F..F (maxpos).
//    Scale < -(N-2)*2^ES gives mag 0x00..1 (minpos).
//    Rounding never yields 0 or NaR from a finite nonzero input.
//  - Sign: out = in_sign ? -mag : mag (two's complement, N bits).
//  - Specials: in_inf wins over in_zero and gives out={1,0..0}, out_inf=1.
//    in_zero gives out=0, out_zero=1. For specials, scale/frac are don't-care.
// CONFIGURATION
//  - POSIT_ENC_STATS_EN defined: adds outputs sat_cnt[15:0] and rnd_up_cnt[15:0].
//    Counters increment on each stage-2 transfer that saturated / rounded up.
//    They saturate at 0xFFFF and clear on rst.
//  - Not defined: these ports and the counter logic are absent; behaviour is otherwise identical.
// STRUCTURE
//  - Shared package posit_pkg: log2 function, SW derivation, NaR/zero/maxpos/minpos constants.
//  - One sub-module, posit_regime_shift: combinational regime build + right shift + guard/sticky extract.
//    It is instantiated in stage 1.
//  - Top level holds the pipeline registers, handshake, rounding, sign and stats.
// TESTING  (N=8, ES=4, FW=8, out_ready=1 unless stated)
//  - scale=0, frac=8'b1000_0000, sign=0 -> out=8'h40 two cycles after accept.
//    With sign=1 -> 8'hC0.
//  - scale=16 -> 8'h60; scale=-16 -> 8'h20.
//    scale=200 -> 8'h7F; scale=-200 -> 8'h01; scale=-200, sign=1 -> 8'hFF.
//  - RNE at scale=0: frac=8'b1100_0000 -> 8'h41; frac=8'b1010_0000 (tie, lsb 0) -> 8'h40;
//    same frac with in_sticky=1 -> 8'h41; frac=8'b1110_0000 (tie, lsb 1) -> 8'h42.
//  - in_inf=1 & in_zero=1 -> out=8'h80, out_inf=1, out_zero=0.
//    in_zero alone -> out=8'h00, out_zero=1.
//  - Backpressure: 4 back-to-back inputs with out_ready=0 for 5 cycles.
//    in_ready drops after 2 accepts; all 4 results emerge in order after release, none lost.
//  - Reset asserted one cycle after an accept: out_valid stays 0 and in_ready=0 during rst.
//    in_ready=1 the cycle after rst falls.
//    With POSIT_ENC_STATS_EN, the counters read 0.

Source files
------------

// File: rtl/posit_pkg.sv
// Shared definitions for the posit datapath.
// Provides the width helpers (log2, scale width) and the special encodings
// (NaR, zero, maxpos, minpos) as functions of the posit width, so every
// module derives them from its own N.
package posit_pkg;

  // Ceiling log2, used to size the regime-count part of the scale.
  function automatic int posit_log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Signed scale width: regime count bits + exponent bits + sign/headroom.
  function automatic int posit_sw(input int n, input int es);
    return posit_log2(n) + es + 2;
  endfunction

  // Not-a-Real: sign bit only.
  function automatic logic [63:0] posit_nar(input int n);
    return 64'd1 << (n - 1);
  endfunction

  function automatic logic [63:0] posit_zero(input int n);
    return (n > 0) ? 64'd0 : 64'd0;
  endfunction

  // Largest positive magnitude: 0111...1.
  function automatic logic [63:0] posit_maxpos(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  // Smallest positive magnitude: 000...1.
  function automatic logic [63:0] posit_minpos(input int n);
    return (n > 0) ? 64'd1 : 64'd0;
  endfunction

endpackage

// File: rtl/posit_regime_shift.sv
// Combinational regime build and alignment for the posit encoder.
// Splits the signed scale into regime count k and exponent e, forms the bit
// string {regime, e, fraction-without-hidden-bit}, keeps its top N-1 bits and
// extracts the guard bit and the OR of everything below it. Also flags scales
// outside the representable range.
// Ports:
//   scale  in  SW   signed scale = k*2^ES + e
//   frac   in  FW   1.f mantissa, MSB is the hidden bit (not encoded)
//   kept   out N-1  magnitude bits before rounding
//   guard  out 1    first dropped bit
//   sticky out 1    OR of the remaining dropped bits
//   sat_hi out 1    scale above maxpos range
//   sat_lo out 1    scale below minpos range
module posit_regime_shift #(
  parameter int N  = 8,
  parameter int ES = 4,
  parameter int FW = 8,
  parameter int SW = 9
) (
  input  logic [SW-1:0] scale,
  input  logic [FW-1:0] frac,
  output logic [N-2:0]  kept,
  output logic          guard,
  output logic          sticky,
  output logic          sat_hi,
  output logic          sat_lo
);

  localparam int TW = ES + FW - 1;   // exponent + explicit fraction bits
  localparam int PW = TW + 2;        // plus the minimal 2-bit regime
  localparam int WD = PW + N - 1;    // room for the longest regime run

  localparam logic signed [SW-1:0] SAT_LIM = SW'((N - 2) << ES);
  localparam logic signed [SW-1:0] K_MAX   = SW'(N - 2);
  localparam logic signed [SW-1:0] K_MIN   = SW'(1 - N);

  logic signed [SW-1:0] scale_s;
  logic signed [SW-1:0] k_s;
  logic signed [SW-1:0] kc_s;
  logic        [SW-1:0] rs_s;
  logic        [PW-1:0] pre_s;
  logic signed [WD-1:0] body_s;
  logic signed [WD-1:0] shifted_s;
  logic                 unused_hidden_s;

  assign unused_hidden_s = frac[FW-1];

  // Regime construction: the 2-bit seed "10"/"01" is stretched by an
  // arithmetic shift, whose fill bit equals the seed MSB, i.e. the regime run.
  always_comb begin
    scale_s = $signed(scale);
    k_s     = scale_s >>> ES;
    if (k_s > K_MAX) begin
      kc_s = K_MAX;
    end else if (k_s < K_MIN) begin
      kc_s = K_MIN;
    end else begin
      kc_s = k_s;
    end
    if (kc_s[SW-1]) begin
      pre_s = {2'b01, scale[ES-1:0], frac[FW-2:0]};
      rs_s  = ~kc_s;                 // -k-1 extra zeros
    end else begin
      pre_s = {2'b10, scale[ES-1:0], frac[FW-2:0]};
      rs_s  = kc_s;                  // k extra ones
    end
    body_s    = $signed({pre_s, {(N-1){1'b0}}});
    shifted_s = body_s >>> rs_s;
    kept      = shifted_s[WD-1 -: N-1];
    guard     = shifted_s[WD-N];
    sticky    = |shifted_s[WD-N-1:0];
    sat_hi    = (scale_s > SAT_LIM);
    sat_lo    = (scale_s < -SAT_LIM);
  end

endmodule

// File: rtl/posit_round_encode_pipe.sv
// Output stage of the posit multiply datapath: regime/exponent/fraction packing,
// round-to-nearest-even, saturation, sign application and special encodings,
// through a 2-stage valid/ready pipeline (latency 2, throughput 1/cycle).
// Optional feature macro: POSIT_ENC_STATS_EN adds sat_cnt / rnd_up_cnt.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      upstream handshake
//   in_sign, in_scale,       unrounded product fields
//   in_frac, in_sticky
//   in_inf, in_zero          special results (inf wins)
//   out_valid / out_ready    downstream handshake
//   out, out_inf, out_zero   encoded posit and special flags
//   sat_cnt, rnd_up_cnt      (POSIT_ENC_STATS_EN only) event counters
module posit_round_encode_pipe
  import posit_pkg::*;
#(
  parameter int N  = 8,
  parameter int ES = 4,
  parameter int FW = N,
  localparam int SW = posit_sw(N, ES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic [SW-1:0] in_scale,
  input  logic [FW-1:0] in_frac,
  input  logic          in_sticky,
  input  logic          in_inf,
  input  logic          in_zero,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out,
  output logic          out_inf,
`ifdef POSIT_ENC_STATS_EN
  output logic [15:0]   sat_cnt,
  output logic [15:0]   rnd_up_cnt,
`endif
  output logic          out_zero
);

  localparam logic [63:0]  NAR_W    = posit_nar(N);
  localparam logic [63:0]  ZERO_W   = posit_zero(N);
  localparam logic [63:0]  MAXPOS_W = posit_maxpos(N);
  localparam logic [63:0]  MINPOS_W = posit_minpos(N);
  localparam logic [N-1:0] NAR      = NAR_W[N-1:0];
  localparam logic [N-1:0] ZERO_N   = ZERO_W[N-1:0];
  localparam logic [N-1:0] MAXPOS   = MAXPOS_W[N-1:0];
  localparam logic [N-1:0] MINPOS   = MINPOS_W[N-1:0];
  localparam logic [N-1:0] ONE_N    = {{(N-1){1'b0}}, 1'b1};

  // handshake
  logic s2_adv_s;
  logic s1_adv_s;

  // stage-1 combinational results
  logic [N-2:0] rs_kept_s;
  logic         rs_guard_s;
  logic         rs_sticky_s;
  logic         rs_sat_hi_s;
  logic         rs_sat_lo_s;

  // stage-1 registers
  logic         s1_valid_r;
  logic         s1_sign_r;
  logic         s1_inf_r;
  logic         s1_zero_r;
  logic         s1_sat_hi_r;
  logic         s1_sat_lo_r;
  logic [N-2:0] s1_kept_r;
  logic         s1_guard_r;
  logic         s1_sticky_r;

  // stage-2 combinational results
  logic         rnd_up_s;
  logic [N-1:0] mag_s;
  logic [N-1:0] signed_s;
  logic [N-1:0] enc_s;
  logic         enc_inf_s;
  logic         enc_zero_s;

  assign s2_adv_s = ~out_valid | out_ready;
  assign s1_adv_s = ~s1_valid_r | s2_adv_s;
  assign in_ready = s1_adv_s & ~rst;

  posit_regime_shift #(
    .N  (N),
    .ES (ES),
    .FW (FW),
    .SW (SW)
  ) u_regime_shift (
    .scale  (in_scale),
    .frac   (in_frac),
    .kept   (rs_kept_s),
    .guard  (rs_guard_s),
    .sticky (rs_sticky_s),
    .sat_hi (rs_sat_hi_s),
    .sat_lo (rs_sat_lo_s)
  );

  // Stage-2 rounding, saturation, sign and special selection.
  // A round carry out of the fraction simply ripples into exponent/regime;
  // it cannot pass maxpos because the all-ones pattern always has guard=0.
  always_comb begin
    rnd_up_s = s1_guard_r & (s1_kept_r[0] | s1_sticky_r);
    if (s1_sat_hi_r) begin
      mag_s = MAXPOS;
    end else if (s1_sat_lo_r) begin
      mag_s = MINPOS;
    end else begin
      mag_s = {1'b0, s1_kept_r} + (rnd_up_s ? ONE_N : ZERO_N);
    end
    signed_s = s1_sign_r ? (~mag_s + ONE_N) : mag_s;
    if (s1_inf_r) begin
      enc_s      = NAR;
      enc_inf_s  = 1'b1;
      enc_zero_s = 1'b0;
    end else if (s1_zero_r) begin
      enc_s      = ZERO_N;
      enc_inf_s  = 1'b0;
      enc_zero_s = 1'b1;
    end else begin
      enc_s      = signed_s;
      enc_inf_s  = 1'b0;
      enc_zero_s = 1'b0;
    end
  end

  // Pipeline registers for both stages; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r  <= 1'b0;
      s1_sign_r   <= 1'b0;
      s1_inf_r    <= 1'b0;
      s1_zero_r   <= 1'b0;
      s1_sat_hi_r <= 1'b0;
      s1_sat_lo_r <= 1'b0;
      s1_kept_r   <= {(N-1){1'b0}};
      s1_guard_r  <= 1'b0;
      s1_sticky_r <= 1'b0;
      out_valid   <= 1'b0;
      out         <= ZERO_N;
      out_inf     <= 1'b0;
      out_zero    <= 1'b0;
    end else begin
      if (s1_adv_s) begin
        s1_valid_r <= in_valid;
        if (in_valid) begin
          s1_sign_r   <= in_sign;
          s1_inf_r    <= in_inf;
          s1_zero_r   <= in_zero;
          s1_sat_hi_r <= rs_sat_hi_s;
          s1_sat_lo_r <= rs_sat_lo_s;
          s1_kept_r   <= rs_kept_s;
          s1_guard_r  <= rs_guard_s;
          s1_sticky_r <= rs_sticky_s | in_sticky;
        end
      end
      if (s2_adv_s) begin
        out_valid <= s1_valid_r;
        if (s1_valid_r) begin
          out      <= enc_s;
          out_inf  <= enc_inf_s;
          out_zero <= enc_zero_s;
        end
      end
    end
  end

`ifdef POSIT_ENC_STATS_EN
  logic s2_xfer_s;
  logic sat_evt_s;
  logic rnd_evt_s;

  assign s2_xfer_s = s1_valid_r & s2_adv_s & ~s1_inf_r & ~s1_zero_r;
  assign sat_evt_s = s2_xfer_s & (s1_sat_hi_r | s1_sat_lo_r);
  assign rnd_evt_s = s2_xfer_s & ~s1_sat_hi_r & ~s1_sat_lo_r & rnd_up_s;

  // Saturating event counters for saturation and round-up occurrences.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_cnt    <= 16'h0000;
      rnd_up_cnt <= 16'h0000;
    end else begin
      if (sat_evt_s && (sat_cnt != 16'hFFFF)) begin
        sat_cnt <= sat_cnt + 16'h0001;
      end
      if (rnd_evt_s && (rnd_up_cnt != 16'hFFFF)) begin
        rnd_up_cnt <= rnd_up_cnt + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_posit_round_encode_pipe.sv
// Self-checking bench for posit_round_encode_pipe (N=8, ES=4, FW=8).
// Directed spec vectors, backpressure, reset-in-flight and randomized traffic
// checked against a bit-string reference model and an in-order scoreboard.
module tb_posit_round_encode_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       in_sign;
  logic [8:0] in_scale;
  logic [7:0] in_frac;
  logic       in_sticky;
  logic       in_inf;
  logic       in_zero;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic       out_inf;
  logic       out_zero;
`ifdef POSIT_ENC_STATS_EN
  logic [15:0] sat_cnt;
  logic [15:0] rnd_up_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit lat_en   = 1'b0;
  bit held_v   = 1'b0;
  logic [9:0] held_val;
  logic [9:0] pend_exp;
  string      pend_tag;
  logic [9:0] exp_q[$];
  string      tag_q[$];
  int         acc_cyc_q[$];

  posit_round_encode_pipe #(.N(8), .ES(4), .FW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_scale  (in_scale),
    .in_frac   (in_frac),
    .in_sticky (in_sticky),
    .in_inf    (in_inf),
    .in_zero   (in_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_inf   (out_inf),
`ifdef POSIT_ENC_STATS_EN
    .sat_cnt   (sat_cnt),
    .rnd_up_cnt(rnd_up_cnt),
`endif
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: build the posit bit string literally, then round to nearest even.
  function automatic logic [9:0] ref_enc(input bit sign, input int scale, input logic [7:0] frac,
                                         input bit stk, input bit inf, input bit zero);
    bit bits[$];
    int k;
    int e;
    logic [7:0] mag;
    bit g;
    bit st;
    if (inf) return {1'b1, 1'b0, 8'h80};
    if (zero) return {1'b0, 1'b1, 8'h00};
    if (scale > 96) begin
      mag = 8'h7F;
    end else if (scale < -96) begin
      mag = 8'h01;
    end else begin
      k = scale >>> 4;
      e = scale - k * 16;
      if (k >= 0) begin
        repeat (k + 1) bits.push_back(1'b1);
        bits.push_back(1'b0);
      end else begin
        repeat (-k) bits.push_back(1'b0);
        bits.push_back(1'b1);
      end
      for (int i = 3; i >= 0; i--) bits.push_back(((e >> i) & 1) != 0);
      for (int i = 6; i >= 0; i--) bits.push_back(frac[i]);
      mag = 8'h00;
      for (int i = 0; i < 7; i++) mag = {mag[6:0], bits[i]};
      g  = bits[7];
      st = stk;
      for (int i = 8; i < bits.size(); i++) st = st | bits[i];
      if (g && (mag[0] || st)) mag = mag + 8'd1;
    end
    return {1'b0, 1'b0, sign ? 8'(8'd0 - mag) : mag};
  endfunction

  // One clock: evaluate handshakes mid-cycle, score outputs, then advance.
  task automatic tick(output bit acc);
    bit fire;
    logic [9:0] cur;
    #1;
    acc  = in_valid & in_ready;
    fire = out_valid & out_ready;
    cur  = {out_inf, out_zero, out};
    if (held_v) begin
      check_eq("hold_valid", 32'(out_valid), 32'd1);
      check_eq("hold_data", 32'(cur), 32'(held_val));
    end
    if (fire) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        check_eq(tag_q.pop_front(), 32'(cur), 32'(exp_q.pop_front()));
        if (lat_en) check_eq("latency", 32'(cyc - acc_cyc_q[0]), 32'd2);
        void'(acc_cyc_q.pop_front());
      end
    end
    held_v   = out_valid & ~out_ready;
    held_val = cur;
    if (acc) begin
      exp_q.push_back(pend_exp);
      tag_q.push_back(pend_tag);
      acc_cyc_q.push_back(cyc);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive(input bit sign, input int scale, input logic [7:0] frac,
                       input bit stk, input bit inf, input bit zero);
    in_sign   = sign;
    in_scale  = 9'(scale);
    in_frac   = frac;
    in_sticky = stk;
    in_inf    = inf;
    in_zero   = zero;
  endtask

  task automatic send(input bit sign, input int scale, input logic [7:0] frac, input bit stk,
                      input bit inf, input bit zero, input logic [9:0] exp, input string tag);
    bit acc;
    int n;
    drive(sign, scale, frac, stk, inf, zero);
    pend_exp = exp;
    pend_tag = tag;
    in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      tick(acc);
      n++;
    end
    if (!acc) check_eq("accept_timeout", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    in_valid = 1'b0;
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick(acc);
    check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bit acc;
    int idx;
    int n_acc;
    int sc[4];
    logic [7:0] fr[4];
    bit have;
    bit r_sign, r_stk, r_inf, r_zero;
    int r_sc;
    logic [7:0] r_fr;
    int sel;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 0, 8'h80, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out", 32'({out_inf, out_zero, out}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors with out_ready held high; latency must be exactly 2.
    lat_en = 1'b1;
    send(1'b0,    0, 8'b1000_0000, 1'b0, 1'b0, 1'b0, 10'h040, "s0_pos");
    send(1'b1,    0, 8'b1000_0000, 1'b0, 1'b0, 1'b0, 10'h0C0, "s0_neg");
    send(1'b0,   16, 8'b1000_0000, 1'b0, 1'b0, 1'b0, 10'h060, "s16");
    send(1'b0,  -16, 8'b1000_0000, 1'b0, 1'b0, 1'b0, 10'h020, "sm16");
    send(1'b0,  200, 8'b1000_0000, 1'b0, 1'b0, 1'b0, 10'h07F, "sat_max");
    send(1'b0, -200, 8'b1000_0000, 1'b0, 1'b0, 1'b0, 10'h001, "sat_min");
    send(1'b1, -200, 8'b1000_0000, 1'b0, 1'b0, 1'b0, 10'h0FF, "sat_min_neg");
    send(1'b0,    0, 8'b1100_0000, 1'b0, 1'b0, 1'b0, 10'h041, "rne_c0");
    send(1'b0,    0, 8'b1010_0000, 1'b0, 1'b0, 1'b0, 10'h040, "rne_tie_even");
    send(1'b0,    0, 8'b1010_0000, 1'b1, 1'b0, 1'b0, 10'h041, "rne_tie_stk");
    send(1'b0,    0, 8'b1110_0000, 1'b0, 1'b0, 1'b0, 10'h042, "rne_tie_odd");
    send(1'b0,   37, 8'hA5,        1'b0, 1'b1, 1'b1, 10'h280, "inf_wins");
    send(1'b1,   37, 8'hA5,        1'b0, 1'b0, 1'b1, 10'h100, "zero");
    send(1'b0,   96, 8'hFF, 1'b1, 1'b0, 1'b0, ref_enc(1'b0,  96, 8'hFF, 1'b1, 1'b0, 1'b0), "b96");
    send(1'b0,   97, 8'h80, 1'b0, 1'b0, 1'b0, ref_enc(1'b0,  97, 8'h80, 1'b0, 1'b0, 1'b0), "b97");
    send(1'b0,   95, 8'hFF, 1'b0, 1'b0, 1'b0, ref_enc(1'b0,  95, 8'hFF, 1'b0, 1'b0, 1'b0), "b95_carry");
    send(1'b1,  -96, 8'hFF, 1'b1, 1'b0, 1'b0, ref_enc(1'b1, -96, 8'hFF, 1'b1, 1'b0, 1'b0), "bm96");
    send(1'b0,  -97, 8'hFF, 1'b1, 1'b0, 1'b0, ref_enc(1'b0, -97, 8'hFF, 1'b1, 1'b0, 1'b0), "bm97");
    send(1'b0,  -81, 8'hC3, 1'b0, 1'b0, 1'b0, ref_enc(1'b0, -81, 8'hC3, 1'b0, 1'b0, 1'b0), "bm81");
    drain();
    lat_en = 1'b0;

    // Backpressure: 4 back-to-back inputs while the sink stalls for 5 cycles.
    for (int i = 0; i < 4; i++) begin
      sc[i] = int'($urandom_range(160)) - 80;
      fr[i] = {1'b1, 7'($urandom)};
    end
    out_ready = 1'b0;
    idx = 0;
    n_acc = 0;
    for (int c = 0; c < 5; c++) begin
      if (idx < 4) begin
        drive(1'b0, sc[idx], fr[idx], 1'b0, 1'b0, 1'b0);
        pend_exp = ref_enc(1'b0, sc[idx], fr[idx], 1'b0, 1'b0, 1'b0);
        pend_tag = "bp_data";
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick(acc);
      if (acc) begin
        idx++;
        n_acc++;
      end
    end
    #1;
    check_eq("bp_accepts", 32'(n_acc), 32'd2);
    check_eq("bp_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 50 && idx < 4; c++) begin
      drive(1'b0, sc[idx], fr[idx], 1'b0, 1'b0, 1'b0);
      pend_exp = ref_enc(1'b0, sc[idx], fr[idx], 1'b0, 1'b0, 1'b0);
      pend_tag = "bp_data";
      in_valid = 1'b1;
      tick(acc);
      if (acc) idx++;
    end
    check_eq("bp_all_accepted", 32'(idx), 32'd4);
    drain();

    // Reset one cycle after an accept: the in-flight item must vanish.
    send(1'b0, 16, 8'h80, 1'b0, 1'b0, 1'b0, 10'h060, "pre_rst");
    rst = 1'b1;
    exp_q.delete();
    tag_q.delete();
    acc_cyc_q.delete();
    held_v = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      check_eq("rst_in_ready_mid", 32'(in_ready), 32'd0);
      check_eq("rst_out_valid_mid", 32'(out_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("post_rst_out", 32'({out_valid, out_inf, out_zero, out}), 32'd0);
`ifdef POSIT_ENC_STATS_EN
    check_eq("post_rst_sat_cnt", 32'(sat_cnt), 32'd0);
    check_eq("post_rst_rnd_cnt", 32'(rnd_up_cnt), 32'd0);
`endif
    @(negedge clk);
    repeat (4) tick(acc);

    // Randomized traffic with random source gaps and sink stalls.
    have = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!have) begin
        sel    = int'($urandom_range(9));
        r_inf  = (sel == 0);
        r_zero = (sel == 1) || ((sel == 0) && ($urandom_range(1) == 1));
        r_sign = 1'($urandom);
        r_stk  = 1'($urandom);
        r_fr   = {1'b1, 7'($urandom)};
        if ($urandom_range(1) == 1) r_sc = int'($urandom_range(220)) - 110;
        else r_sc = int'($urandom_range(511)) - 256;
        have = 1'b1;
      end
      drive(r_sign, r_sc, r_fr, r_stk, r_inf, r_zero);
      pend_exp  = ref_enc(r_sign, r_sc, r_fr, r_stk, r_inf, r_zero);
      pend_tag  = "rnd_data";
      in_valid  = ($urandom_range(4) != 0);
      out_ready = ($urandom_range(3) != 0);
      tick(acc);
      if (acc) have = 1'b0;
    end
    out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
